tcb_lite_peri_gpio_filter: RTL and testbench
============================================

Name: tcb_lite_peri_gpio_filter

Overview:
- Input conditioning stage directly upstream of the TCB-Lite GPIO peripheral's `gpio_i` port.
- Synchronizes asynchronous pad inputs into the `clk` domain.
- Applies a per-bit debounce/glitch filter timed by a shared prescaler, then emits the filtered level plus one-cycle rise/fall event pulses.
- GPIO or interrupt logic consumes these outputs. The block has no bus interface; configuration inputs come from a register block.

Parameters:
- GDW, 32, GPIO width (bits).
- CDC, 2, synchronizer depth in flops; 0 = inputs already synchronous, no sync stage.
- CNW, 16, prescaler counter/compare width.
- FLW, 4, per-bit filter counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous assert, active-high
- gpio_a  input  GDW  raw pad inputs, asynchronous to clk
- cfg_div  input  CNW  prescaler period; sample tick every cfg_div+1 cycles
- cfg_len  input  FLW  filter length; cfg_len+1 consecutive mismatching ticks required
- cfg_byp  input  GDW  per-bit filter bypass
- gpio_f  output  GDW  filtered level (connects to GPIO gpio_i)
- evt_r  output  GDW  rising-edge pulse on gpio_f
- evt_f  output  GDW  falling-edge pulse on gpio_f
- tick  output  1  prescaler sample strobe (debug/observation)

Behaviour:
- Reset: asynchronous, active-high. While rst=1, all flops clear:
  - sync chain, prescaler counter, filter counters, gpio_f, delayed copy: 0
  - outputs gpio_f=0, evt_r=0, evt_f=0, tick=0
  - first cycle after release behaves as from reset state; no events generated by reset itself.
- Synchronizer:
  - CDC-flop chain per bit; `sync` is the last stage.
  - CDC=0: sync = gpio_a combinationally.
- Prescaler:
  - CNW-bit counter `pcnt`, registered `tick`.
  - If pcnt >= cfg_div: tick<=1, pcnt<=0; else tick<=0, pcnt<=pcnt+1.
  - cfg_div=0: tick high every cycle after the first post-reset cycle.
  - Lowering cfg_div below the current pcnt produces a tick on the next cycle. No wrap past cfg_div is possible.
- Filter, per bit i, when cfg_byp[i]=0 and tick=1:
  - If sync[i]==gpio_f[i]: fcnt[i]<=0.
  - Else if fcnt[i]==cfg_len: gpio_f[i]<=sync[i], fcnt[i]<=0.
  - Else fcnt[i]<=fcnt[i]+1 (cannot overflow, since cfg_len ≤ 2^FLW−1).
  - tick=0: state held.
  - A glitch shorter than cfg_len+1 ticks never reaches gpio_f; any matching tick restarts the count.
- Bypass, cfg_byp[i]=1:
  - gpio_f[i]<=sync[i] every cycle, fcnt[i]<=0, regardless of tick.
  - Clearing bypass resumes filtering from fcnt=0.
- Changing cfg_len mid-count: compare uses the current value. If fcnt already exceeds the new cfg_len, keep incrementing. Count is FLW-bit wrapping, so a toggle occurs when it wraps around to equal cfg_len. This is an accepted corner; software programs cfg_len while idle.
- Events:
  - Registered copy `gpio_d` of gpio_f.
  - evt_r = gpio_f & ~gpio_d; evt_f = ~gpio_f & gpio_d.
  - Each is exactly one cycle, coincident with the first cycle of the new gpio_f level. Both apply in bypass mode.
- Latency with gpio_a stable before edge 0 and cfg_div=0:
  - Filtered: gpio_f changes after edge CDC+1+cfg_len.
  - Bypass: after edge CDC+1.
  - General (filtered): CDC + up to cfg_div+1 cycles of tick alignment + (cfg_len+1) ticks.
- Simultaneous rise/fall on different bits is independent. A single bit cannot produce evt_r and evt_f in the same cycle.

Decomposition:
- tcb_lite_pkg: no new types required. Optionally add a `gpio_filter_cfg_t` struct (div, len, byp) for register-block hookup.
- One natural sub-module: `tcb_lite_lib_sync`, the parameterized CDC flop chain (width, depth), reusable by the GPIO peripheral itself.
- Prescaler and filter stay in the top module.

Test Plan:
- Reset release, gpio_a=32'h0000_0000 → gpio_f, evt_r, evt_f all 0; no events in the first 10 cycles.
- Bypass all (cfg_byp=32'hffffffff), CDC=2, gpio_a 0→32'h89abcdef before edge 0 → gpio_f=32'h89abcdef after edge 3; evt_r=32'h89abcdef for exactly one cycle.
- Filter, cfg_div=0, cfg_len=3, byp=0, bit0 pulse 3 cycles wide → gpio_f[0] stays 0. Pulse 5 cycles wide → gpio_f[0]=1 after edge CDC+4, evt_r[0] one cycle.
- Prescaler, cfg_div=4 → tick period 5 cycles. With cfg_len=1, a stable change reaches gpio_f within 2–3 ticks (CDC+5..CDC+15 cycles).
- Falling edge: gpio_f=32'hfedcba98 → gpio_a=0, bypass → evt_f=32'hfedcba98 one cycle, evt_r=0.
- Async reset asserted mid-count (fcnt=2, between clock edges) → outputs 0 immediately. After release, counting restarts from 0 and no spurious evt_f is produced.

Source files
------------

// File: rtl/tcb_lite_peri_gpio_filter_pkg.sv
// Shared defaults and register-block hookup type for the GPIO input filter.
package tcb_lite_peri_gpio_filter_pkg;

  localparam int unsigned GDW_DEF = 32;
  localparam int unsigned CDC_DEF = 2;
  localparam int unsigned CNW_DEF = 16;
  localparam int unsigned FLW_DEF = 4;

  typedef struct packed {
    logic [CNW_DEF-1:0] div;
    logic [FLW_DEF-1:0] len;
    logic [GDW_DEF-1:0] byp;
  } gpio_filter_cfg_t;

endpackage

// File: rtl/tcb_lite_peri_gpio_filter_if.sv
// Pad inputs, filter configuration and conditioned outputs of the GPIO input filter.
interface tcb_lite_peri_gpio_filter_if
  import tcb_lite_peri_gpio_filter_pkg::*;
#(
  parameter int unsigned GDW = GDW_DEF,
  parameter int unsigned CNW = CNW_DEF,
  parameter int unsigned FLW = FLW_DEF
);
  logic [GDW-1:0] gpio_a;
  logic [CNW-1:0] cfg_div;
  logic [FLW-1:0] cfg_len;
  logic [GDW-1:0] cfg_byp;
  logic [GDW-1:0] gpio_f;
  logic [GDW-1:0] evt_r;
  logic [GDW-1:0] evt_f;
  logic           tick;

  modport master (
    output gpio_a, cfg_div, cfg_len, cfg_byp,
    input  gpio_f, evt_r, evt_f, tick
  );

  modport slave (
    input  gpio_a, cfg_div, cfg_len, cfg_byp,
    output gpio_f, evt_r, evt_f, tick
  );
endinterface

// File: rtl/tcb_lite_peri_gpio_filter_sync.sv
// Parameterized flop-chain synchronizer; D=0 passes the input straight through.
module tcb_lite_peri_gpio_filter_sync #(
  parameter int unsigned W = 1,
  parameter int unsigned D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (D == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_chain
    logic [W-1:0] sync_q [D];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(D); i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < int'(D); i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign q_o = sync_q[D-1];
  end
endmodule

// File: rtl/tcb_lite_peri_gpio_filter.sv
// GPIO input conditioning: pad synchronizer, shared prescaler, per-bit debounce and edge events.
module tcb_lite_peri_gpio_filter
  import tcb_lite_peri_gpio_filter_pkg::*;
#(
  parameter int unsigned GDW = GDW_DEF,
  parameter int unsigned CDC = CDC_DEF,
  parameter int unsigned CNW = CNW_DEF,
  parameter int unsigned FLW = FLW_DEF
) (
  input logic                         clk,
  input logic                         rst,
  tcb_lite_peri_gpio_filter_if.slave  gpio_if
);
  logic [GDW-1:0] sync;
  logic [CNW-1:0] pcnt_q, pcnt_d;
  logic           tick_q, tick_d;
  logic [GDW-1:0] gpio_f_q, gpio_f_d;
  logic [GDW-1:0] gpio_dly_q;
  logic [FLW-1:0] fcnt_q [GDW];
  logic [FLW-1:0] fcnt_d [GDW];

  tcb_lite_peri_gpio_filter_sync #(.W(GDW), .D(CDC)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gpio_if.gpio_a),
    .q_o (sync)
  );

  // >= rather than == so lowering cfg_div below pcnt ticks at once instead of wrapping
  always_comb begin
    if (pcnt_q >= gpio_if.cfg_div) begin
      tick_d = 1'b1;
      pcnt_d = '0;
    end else begin
      tick_d = 1'b0;
      pcnt_d = pcnt_q + CNW'(1);
    end
  end

  always_comb begin
    gpio_f_d = gpio_f_q;
    fcnt_d   = fcnt_q;
    for (int i = 0; i < int'(GDW); i++) begin
      if (gpio_if.cfg_byp[i]) begin
        gpio_f_d[i] = sync[i];
        fcnt_d[i]   = '0;
      end else if (tick_q) begin
        if (sync[i] == gpio_f_q[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == gpio_if.cfg_len) begin
          gpio_f_d[i] = sync[i];
          fcnt_d[i]   = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FLW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q     <= '0;
      tick_q     <= 1'b0;
      gpio_f_q   <= '0;
      gpio_dly_q <= '0;
      for (int i = 0; i < int'(GDW); i++) fcnt_q[i] <= '0;
    end else begin
      pcnt_q     <= pcnt_d;
      tick_q     <= tick_d;
      gpio_f_q   <= gpio_f_d;
      gpio_dly_q <= gpio_f_q;
      fcnt_q     <= fcnt_d;
    end
  end

  assign gpio_if.gpio_f = gpio_f_q;
  assign gpio_if.evt_r  = gpio_f_q & ~gpio_dly_q;
  assign gpio_if.evt_f  = ~gpio_f_q & gpio_dly_q;
  assign gpio_if.tick   = tick_q;
endmodule

// File: tb/tb_tcb_lite_peri_gpio_filter.sv
// Randomized and directed bench for the GPIO input filter against a cycle-count reference model.
module tb_tcb_lite_peri_gpio_filter;
  localparam int unsigned GDW = 32;
  localparam int unsigned CDC = 2;
  localparam int unsigned CNW = 16;
  localparam int unsigned FLW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcb_lite_peri_gpio_filter_if #(.GDW(GDW), .CNW(CNW), .FLW(FLW)) gpio_if ();

  tcb_lite_peri_gpio_filter #(.GDW(GDW), .CDC(CDC), .CNW(CNW), .FLW(FLW)) dut (
    .clk     (clk),
    .rst     (rst),
    .gpio_if (gpio_if)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // reference model: pad history queue, per-bit mismatch run counters, tick from cycle count
  logic [31:0] a_drv;
  logic [31:0] m_f, m_fprev, m_byp;
  logic [31:0] m_sq[$];
  int          m_cnt[32];
  int          m_k, m_div, m_len;
  logic        m_tick;

  int          hit_r0, hit_f0, tcount;
  logic [31:0] ev_or;

  task automatic drive(input logic [31:0] a);
    a_drv = a;
    gpio_if.gpio_a = a;
  endtask

  task automatic set_len(input int len);
    m_len = len;
    gpio_if.cfg_len = 4'(len);
  endtask

  task automatic set_byp(input logic [31:0] byp);
    m_byp = byp;
    gpio_if.cfg_byp = byp;
  endtask

  task automatic model_reset();
    m_f = '0;
    m_fprev = '0;
    m_sq.delete();
    for (int i = 0; i < int'(CDC); i++) m_sq.push_back(32'h0);
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_k = 0;
    m_tick = 1'b0;
  endtask

  task automatic apply_reset(input int div, input int len, input logic [31:0] byp);
    rst = 1'b1;
    m_div = div;
    gpio_if.cfg_div = 16'(div);
    set_len(len);
    set_byp(byp);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio_f", gpio_if.gpio_f, 32'h0);
    check("rst_evt_r", gpio_if.evt_r, 32'h0);
    check("rst_evt_f", gpio_if.evt_f, 32'h0);
    check("rst_tick", 32'(gpio_if.tick), 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle();
    logic [31:0] s;
    @(posedge clk);
    #1;
    m_k++;
    s = m_sq[0];
    m_fprev = m_f;
    for (int i = 0; i < 32; i++) begin
      if (m_byp[i]) begin
        m_f[i] = s[i];
        m_cnt[i] = 0;
      end else if (m_tick) begin
        if (s[i] == m_f[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == m_len) begin
          m_f[i] = s[i];
          m_cnt[i] = 0;
        end else m_cnt[i] = (m_cnt[i] + 1) % (1 << FLW);
      end
    end
    m_sq.push_back(a_drv);
    void'(m_sq.pop_front());
    m_tick = (m_k % (m_div + 1)) == 0;
    check("gpio_f", gpio_if.gpio_f, m_f);
    check("evt_r", gpio_if.evt_r, m_f & ~m_fprev);
    check("evt_f", gpio_if.evt_f, ~m_f & m_fprev);
    check("tick", 32'(gpio_if.tick), 32'(m_tick));
    if (gpio_if.evt_r[0]) hit_r0++;
    if (gpio_if.evt_f[0]) hit_f0++;
    if (gpio_if.tick) tcount++;
    ev_or = ev_or | gpio_if.evt_r | gpio_if.evt_f;
  endtask

  initial begin
    int rise_e, lat;
    logic [31:0] a;

    drive(32'h0);
    hit_r0 = 0; hit_f0 = 0; tcount = 0; ev_or = '0;

    // reset release, quiet inputs
    apply_reset(0, 0, 32'h0);
    repeat (10) cycle();
    check("rst_no_evt", ev_or, 32'h0);

    // bypass rising
    set_byp(32'hffff_ffff);
    drive(32'h89ab_cdef);
    repeat (3) cycle();
    check("byp_level", gpio_if.gpio_f, 32'h89ab_cdef);
    check("byp_evt_r", gpio_if.evt_r, 32'h89ab_cdef);
    cycle();
    check("byp_evt_r_once", gpio_if.evt_r, 32'h0);

    // bypass falling
    drive(32'hfedc_ba98);
    repeat (5) cycle();
    drive(32'h0);
    repeat (3) cycle();
    check("fall_evt_f", gpio_if.evt_f, 32'hfedc_ba98);
    check("fall_evt_r", gpio_if.evt_r, 32'h0);
    cycle();
    check("fall_evt_f_once", gpio_if.evt_f, 32'h0);

    // glitch filter, len=3, tick every cycle
    apply_reset(0, 3, 32'h0);
    repeat (5) cycle();
    hit_r0 = 0;
    drive(32'h1);
    repeat (3) cycle();
    drive(32'h0);
    repeat (10) cycle();
    check("glitch3_blocked", 32'(hit_r0), 32'h0);
    check("glitch3_level", 32'(gpio_if.gpio_f[0]), 32'h0);

    hit_r0 = 0; hit_f0 = 0; rise_e = -1;
    drive(32'h1);
    for (int e = 1; e <= 14; e++) begin
      cycle();
      if (gpio_if.gpio_f[0] && rise_e < 0) rise_e = e;
      if (e == 5) drive(32'h0);
    end
    check("pulse5_rise_edge", 32'(rise_e), 32'(CDC + 4));
    check("pulse5_evt_r", 32'(hit_r0), 32'h1);
    check("pulse5_evt_f", 32'(hit_f0), 32'h1);

    // prescaler div=4, len=1
    apply_reset(4, 1, 32'h0);
    tcount = 0;
    repeat (50) cycle();
    check("tick_count", 32'(tcount), 32'd10);
    drive(32'hffff_ffff);
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (gpio_if.gpio_f == 32'hffff_ffff && lat < 0) lat = e;
    end
    check("presc_lat_range", 32'(lat >= int'(CDC) + 5 && lat <= int'(CDC) + 15), 32'h1);

    // async reset in the middle of a filter count
    apply_reset(0, 7, 32'hffff_ffff);
    drive(32'hffff_ffff);
    repeat (4) cycle();
    check("pre_rst_level", gpio_if.gpio_f, 32'hffff_ffff);
    set_byp(32'h0);
    drive(32'h0);
    repeat (3) cycle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_gpio_f", gpio_if.gpio_f, 32'h0);
    check("async_rst_evt_f", gpio_if.evt_f, 32'h0);
    check("async_rst_tick", 32'(gpio_if.tick), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ev_or = '0;
    repeat (20) cycle();
    check("post_rst_no_evt", ev_or, 32'h0);
    drive(32'h0000_ffff);
    repeat (15) cycle();

    // randomized phases
    for (int ph = 0; ph < 6; ph++) begin
      apply_reset(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom & $urandom);
      a = $urandom;
      drive(a);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 30) == 0) set_len(int'($urandom_range(0, 5)));
        if ($urandom_range(0, 40) == 0) set_byp($urandom & $urandom);
        if ($urandom_range(0, 1) == 1) a = a ^ ($urandom & $urandom & $urandom & $urandom);
        drive(a);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
